// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit and its control FSM.
package mult_div_unit_pkg;

  localparam int DEF_WIDTH = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MULT = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } md_state_t;

  // Iteration counter width for a given operand width.
  function automatic int md_cnt_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/mult_div_unit_sign_fixup.sv
// sign_fixup: conditional two's-complement negate. Used both to take the
// magnitude of signed operands and to restore the sign of final results.
module mult_div_unit_sign_fixup #(
  parameter int W = 32
) (
  input  logic         i_neg,
  input  logic [W-1:0] i_val,
  output logic [W-1:0] o_val
);

  // Magnitude of the most negative value wraps to itself, which read as
  // unsigned is exactly 2^(W-1) -- the desired abs result.
  assign o_val = i_neg ? (~i_val + W'(1)) : i_val;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative signed multiply/divide: one shift-add or restoring-divide step per
// cycle, W steps per operation, results written to hi/lo with a done pulse.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_mult,
  input  logic             start_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int W  = WIDTH;
  localparam int CW = md_cnt_w(WIDTH);

  md_state_t          r_state, w_state_nxt;
  logic [CW-1:0]      r_cnt;
  logic [2*W-1:0]     r_acc;      // mult: {partial, multiplier}; div: {remainder, dividend/quotient}
  logic [W-1:0]       r_dvs;      // multiplicand or divisor magnitude
  logic               r_sign_q;   // product / quotient sign
  logic               r_sign_r;   // remainder sign (dividend sign)
  logic               r_dz;
  logic [W-1:0]       r_hi, r_lo;

  logic [W-1:0]       w_abs_a, w_abs_b;
  logic               w_b_zero, w_last;
  logic [W:0]         w_madd;
  logic [2*W-1:0]     w_mul_nxt;
  logic [2*W-1:0]     w_sh;
  logic [W:0]         w_trial;
  logic [2*W-1:0]     w_div_nxt;
  logic [2*W-1:0]     w_prod_fix;
  logic [W-1:0]       w_quo_fix, w_rem_fix;

  assign w_b_zero = (b == '0);
  assign w_last   = (r_cnt == CW'(W-1));

  mult_div_unit_sign_fixup #(.W(W)) u_abs_a (
    .i_neg(a[W-1]), .i_val(a), .o_val(w_abs_a)
  );
  mult_div_unit_sign_fixup #(.W(W)) u_abs_b (
    .i_neg(b[W-1]), .i_val(b), .o_val(w_abs_b)
  );

  // Shift-add step: conditionally add multiplicand to the upper half, then shift right.
  assign w_madd    = {1'b0, r_acc[2*W-1:W]} + (r_acc[0] ? {1'b0, r_dvs} : '0);
  assign w_mul_nxt = {w_madd, r_acc[W-1:1]};

  // Restoring step: shift left, trial-subtract divisor, keep if no borrow.
  // The remainder never reaches 2^(W-1), so dropping the top bit on shift is safe.
  assign w_sh      = {r_acc[2*W-2:0], 1'b0};
  assign w_trial   = {1'b0, w_sh[2*W-1:W]} - {1'b0, r_dvs};
  assign w_div_nxt = w_trial[W] ? w_sh : {w_trial[W-1:0], w_sh[W-1:1], 1'b1};

  mult_div_unit_sign_fixup #(.W(2*W)) u_fix_prod (
    .i_neg(r_sign_q), .i_val(w_mul_nxt), .o_val(w_prod_fix)
  );
  mult_div_unit_sign_fixup #(.W(W)) u_fix_quo (
    .i_neg(r_sign_q), .i_val(w_div_nxt[W-1:0]), .o_val(w_quo_fix)
  );
  mult_div_unit_sign_fixup #(.W(W)) u_fix_rem (
    .i_neg(r_sign_r), .i_val(w_div_nxt[2*W-1:W]), .o_val(w_rem_fix)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic; mult wins when both starts arrive together.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start_mult)     w_state_nxt = S_MULT;
        else if (start_div) w_state_nxt = w_b_zero ? S_DONE : S_DIV;
      end
      S_MULT:  if (w_last) w_state_nxt = S_DONE;
      S_DIV:   if (w_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath: operand capture, per-cycle iteration, result write-back.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_dvs    <= '0;
      r_sign_q <= 1'b0;
      r_sign_r <= 1'b0;
      r_dz     <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_mult) begin
            r_acc    <= {{W{1'b0}}, w_abs_a};
            r_dvs    <= w_abs_b;
            r_sign_q <= a[W-1] ^ b[W-1];
            r_sign_r <= 1'b0;
            r_cnt    <= '0;
          end else if (start_div) begin
            if (w_b_zero) begin
              r_dz <= 1'b1;
            end else begin
              r_acc    <= {{W{1'b0}}, w_abs_a};
              r_dvs    <= w_abs_b;
              r_sign_q <= a[W-1] ^ b[W-1];
              r_sign_r <= a[W-1];
              r_cnt    <= '0;
            end
          end
        end
        S_MULT: begin
          r_acc <= w_mul_nxt;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            r_hi <= w_prod_fix[2*W-1:W];
            r_lo <= w_prod_fix[W-1:0];
          end
        end
        S_DIV: begin
          r_acc <= w_div_nxt;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            r_hi <= w_rem_fix;
            r_lo <= w_quo_fix;
          end
        end
        S_DONE: begin
          r_dz  <= 1'b0;
          r_cnt <= '0;
        end
        default: ;
      endcase
    end
  end

  assign busy     = (r_state == S_MULT) || (r_state == S_DIV);
  assign done     = (r_state == S_DONE);
  assign div_zero = r_dz;
  assign hi       = r_hi;
  assign lo       = r_lo;

endmodule
